// File: rtl/controllore_partita_pkg.sv
// rtl/controllore_partita_pkg.sv - shared state, result codes and round limits for the game controller
package controllore_partita_pkg;

  typedef enum logic [2:0] {
    RIPOSO = 3'b000,
    SETUP  = 3'b001,
    GIOCO  = 3'b010,
    FINE   = 3'b100,
    GUASTO = 3'b111
  } stato_t;

  localparam logic [1:0] NESSUNO       = 2'b00;
  localparam logic [1:0] PRIMO_VINCE   = 2'b01;
  localparam logic [1:0] SECONDO_VINCE = 2'b10;
  localparam logic [1:0] PAREGGIO      = 2'b11;

  localparam logic [4:0] BASE_MANCHE = 5'd4;
  localparam logic [4:0] MAX_MANCHE  = 5'd31;

endpackage

// File: rtl/contatore_manche.sv
// rtl/contatore_manche.sv - 5-bit round counter with synchronous clear and saturating enable
module contatore_manche
  import controllore_partita_pkg::*;
(
  input  logic       clk,
  input  logic       i_clr,
  input  logic       i_en,
  output logic [4:0] o_conteggio
);

  logic [4:0] r_conteggio;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_conteggio <= '0;
    end else if (i_en && (r_conteggio < MAX_MANCHE)) begin
      r_conteggio <= r_conteggio + 5'd1;
    end
  end

  assign o_conteggio = r_conteggio;

endmodule

// File: rtl/controllore_partita.sv
// rtl/controllore_partita.sv - game sequencing FSM: setup, round counting, normal end and missing-end fault
module controllore_partita
  import controllore_partita_pkg::*;
(
  input  logic       clk,
  input  logic       INIZIA,
  input  logic [1:0] PRIMO,
  input  logic [1:0] SECONDO,
  input  logic [1:0] MANCHE,
  input  logic [1:0] PARTITA,
  input  logic       FINE_CONTO,
  output logic       INIZIO_SETUP,
  output logic       INIZIO_CONTO,
  output logic [2:0] STATO,
  output logic [4:0] MANCHE_GIOCATE,
  output logic [1:0] VINCITORE,
  output logic       ERRORE
);

  stato_t     r_stato;
  stato_t     w_stato_next;
  logic [4:0] r_limite;
  logic [1:0] r_vincitore;
  logic [4:0] w_manche_giocate;
  logic       w_conta;

  assign w_conta = (r_stato == GIOCO) && (MANCHE != NESSUNO);

  contatore_manche u_contatore (
    .clk         (clk),
    .i_clr       (INIZIA),
    .i_en        (w_conta),
    .o_conteggio (w_manche_giocate)
  );

  always_ff @(posedge clk) begin
    if (INIZIA) begin
      r_stato     <= RIPOSO;
      r_limite    <= '0;
      r_vincitore <= NESSUNO;
    end else begin
      r_stato <= w_stato_next;
      // setup field is 4 bits, so the +4 offset can never overflow 5 bits
      if (r_stato == SETUP) begin
        r_limite <= BASE_MANCHE + {1'b0, SECONDO, PRIMO};
      end
      if ((r_stato == GIOCO) && FINE_CONTO) begin
        r_vincitore <= PARTITA;
      end
    end
  end

  always_comb begin
    w_stato_next = r_stato;
    INIZIO_SETUP = 1'b0;
    INIZIO_CONTO = 1'b0;
    ERRORE       = 1'b0;
    unique case (r_stato)
      RIPOSO: w_stato_next = SETUP;
      SETUP: begin
        INIZIO_SETUP = 1'b1;
        w_stato_next = GIOCO;
      end
      GIOCO: begin
        INIZIO_CONTO = 1'b1;
        // a real end of game wins over the missing-end check
        if (FINE_CONTO) begin
          w_stato_next = FINE;
        end else if (w_manche_giocate >= r_limite) begin
          w_stato_next = GUASTO;
        end
      end
      FINE:   w_stato_next = FINE;
      GUASTO: begin
        ERRORE       = 1'b1;
        w_stato_next = GUASTO;
      end
      default: w_stato_next = RIPOSO;
    endcase
  end

  assign STATO          = r_stato;
  assign MANCHE_GIOCATE = w_manche_giocate;
  assign VINCITORE      = r_vincitore;

endmodule

// File: tb/tb_controllore_partita.sv
// tb/tb_controllore_partita.sv - scoreboard bench for controllore_partita with a behavioural game model
module tb_controllore_partita;

  logic       clk = 1'b0;
  logic       INIZIA = 1'b0;
  logic [1:0] PRIMO = 2'b00;
  logic [1:0] SECONDO = 2'b00;
  logic [1:0] MANCHE = 2'b00;
  logic [1:0] PARTITA = 2'b00;
  logic       FINE_CONTO = 1'b0;
  logic       INIZIO_SETUP;
  logic       INIZIO_CONTO;
  logic [2:0] STATO;
  logic [4:0] MANCHE_GIOCATE;
  logic [1:0] VINCITORE;
  logic       ERRORE;

  controllore_partita dut (
    .clk            (clk),
    .INIZIA         (INIZIA),
    .PRIMO          (PRIMO),
    .SECONDO        (SECONDO),
    .MANCHE         (MANCHE),
    .PARTITA        (PARTITA),
    .FINE_CONTO     (FINE_CONTO),
    .INIZIO_SETUP   (INIZIO_SETUP),
    .INIZIO_CONTO   (INIZIO_CONTO),
    .STATO          (STATO),
    .MANCHE_GIOCATE (MANCHE_GIOCATE),
    .VINCITORE      (VINCITORE),
    .ERRORE         (ERRORE)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] stato;
    logic       setup;
    logic       conto;
    logic [4:0] giocate;
    logic [1:0] vinc;
    logic       err;
  } exp_t;

  exp_t q_exp[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // game model: phase 0 idle, 1 setup, 2 playing, 3 ended, 4 faulted
  int m_phase  = 0;
  int m_limit  = 0;
  int m_rounds = 0;
  int m_win    = 0;

  function automatic logic [2:0] phase_code(input int ph);
    case (ph)
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return 3'b010;
      3:       return 3'b100;
      default: return 3'b111;
    endcase
  endfunction

  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      exp_t e;
      e = q_exp.pop_front();
      n_tests++;
      if ({STATO, INIZIO_SETUP, INIZIO_CONTO, MANCHE_GIOCATE, VINCITORE, ERRORE} !==
          {e.stato, e.setup, e.conto, e.giocate, e.vinc, e.err}) begin
        n_fail++;
        $display("FAIL outputs t=%0t: got stato=%b setup=%b conto=%b giocate=%0d vinc=%b err=%b, want stato=%b setup=%b conto=%b giocate=%0d vinc=%b err=%b",
                 $time, STATO, INIZIO_SETUP, INIZIO_CONTO, MANCHE_GIOCATE, VINCITORE, ERRORE,
                 e.stato, e.setup, e.conto, e.giocate, e.vinc, e.err);
      end
    end
  end

  task automatic step(input logic ini, input logic [1:0] p1, input logic [1:0] p2,
                      input logic [1:0] man, input logic [1:0] par, input logic fc);
    exp_t e;
    int   old_rounds;
    @(negedge clk);
    #1;
    INIZIA     = ini;
    PRIMO      = p1;
    SECONDO    = p2;
    MANCHE     = man;
    PARTITA    = par;
    FINE_CONTO = fc;
    if (ini) begin
      m_phase  = 0;
      m_limit  = 0;
      m_rounds = 0;
      m_win    = 0;
    end else begin
      case (m_phase)
        0: m_phase = 1;
        1: begin
          m_limit = int'(p2) * 4 + int'(p1) + 4;
          m_phase = 2;
        end
        2: begin
          old_rounds = m_rounds;
          if (man != 2'b00 && m_rounds < 31) m_rounds = m_rounds + 1;
          if (fc) begin
            m_win   = int'(par);
            m_phase = 3;
          end else if (old_rounds >= m_limit) begin
            m_phase = 4;
          end
        end
        default: ;
      endcase
    end
    e.stato   = phase_code(m_phase);
    e.setup   = (m_phase == 1);
    e.conto   = (m_phase == 2);
    e.giocate = 5'(m_rounds);
    e.vinc    = 2'(m_win);
    e.err     = (m_phase == 4);
    q_exp.push_back(e);
  endtask

  task automatic new_game(input logic [1:0] p1, input logic [1:0] p2);
    step(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    step(1'b0, p1, p2, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic junk(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom));
  endtask

  initial begin
    // setup with limit 7, then play to the missing-end fault
    new_game(2'b11, 2'b00);
    for (int i = 0; i < 7; i++) step(1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
    step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    junk(3);

    // normal end after 5 P1 rounds
    new_game(2'b11, 2'b11);
    for (int i = 0; i < 5; i++) step(1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
    step(1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1);
    junk(3);

    // undecided rounds interleaved with draws
    new_game(2'b11, 2'b11);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      step(1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
      step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    end
    step(1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1);

    // missing end with limit 4
    new_game(2'b00, 2'b00);
    for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
    step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    junk(3);

    // end and fault condition on the same edge
    new_game(2'b00, 2'b00);
    for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
    step(1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1);
    junk(2);

    // reset in the middle of a game, with INIZIA held for a while
    new_game(2'b11, 2'b11);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 2'b00, 2'b01, 2'b01, 1'b1);
    step(1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
    step(1'b0, 2'b01, 2'b00, 2'b01, 2'b00, 1'b0);
    step(1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0);

    // randomized games
    for (int g = 0; g < 60; g++) begin
      int n;
      new_game(2'($urandom), 2'($urandom));
      n = $urandom_range(2, 26);
      for (int i = 0; i < n; i++) begin
        logic ini;
        logic fc;
        ini = ($urandom_range(0, 39) == 0);
        fc  = ($urandom_range(0, 9) == 0);
        step(ini, 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), fc);
      end
    end

    repeat (2) @(negedge clk);
    #2;
    n_tests++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
